// File: rtl/ks15_arb_pkg.sv
// Shared types, constants and helpers for the ks15 multiplier arbiter.
//   KS_W        operand width (15)
//   KS_PW       raw product width (29)
//   KS_DEF_POLY default low coefficients of the reduction polynomial x^15 + x + 1
//   s1_entry_t  operand stage entry {id, a, b}
//   s2_entry_t  result stage entry {id, d}
//   gf15_reduce reduce a 29-bit product modulo x^15 + poly
package ks15_arb_pkg;

    localparam int unsigned KS_W        = 15;
    localparam int unsigned KS_PW       = 29;
    localparam logic [14:0] KS_DEF_POLY = 15'h0003;
    // Enough id bits for the largest supported requester count (8).
    localparam int unsigned ID_MAXW     = 3;

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [KS_W-1:0]    a;
        logic [KS_W-1:0]    b;
    } s1_entry_t;

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [KS_PW-1:0]   d;
    } s2_entry_t;

    // Clears coefficients x^28..x^15 from the top down; each x^i folds onto
    // x^(i-15) * poly, which only touches lower positions.
    function automatic logic [KS_W-1:0] gf15_reduce(input logic [KS_PW-1:0] p,
                                                     input logic [KS_W-1:0]  poly);
        logic [KS_PW-1:0] r;
        logic [KS_PW-1:0] m;
        r = p;
        m = {13'd0, 1'b1, poly};
        for (int i = KS_PW - 1; i >= int'(KS_W); i--) begin
            if (r[i]) begin
                r = r ^ (m << (i - int'(KS_W)));
            end
        end
        return r[KS_W-1:0];
    endfunction

endpackage

// File: rtl/ks15_mul_arbiter_if.sv
// Request/response bus between NREQ clients and the ks15 multiplier arbiter.
//   master: client side   (drives req_valid, req_a, req_b, rsp_ready)
//   slave : arbiter side  (drives req_ready, rsp_valid, rsp_data, busy)
// Operands of requester i live at [i*15 +: 15]; rsp_data is shared.
interface ks15_mul_arbiter_if
    import ks15_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*KS_W-1:0] req_a;
    logic [NREQ*KS_W-1:0] req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [KS_PW-1:0]     rsp_data;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/ks15.sv
// Combinational 15x15 GF(2) polynomial multiplier, one Karatsuba level.
//   a_i, b_i  15-bit operands (bit i = coefficient of x^i)
//   d_o       29-bit carry-less product
// Split: a = a1*x^8 + a0 (a0 8 bits, a1 7 bits); three 8x8 products.
module ks15 (
    input  logic [14:0] a_i,
    input  logic [14:0] b_i,
    output logic [28:0] d_o
);

    function automatic logic [14:0] clmul8(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                r = r ^ ({7'd0, x} << i);
            end
        end
        return r;
    endfunction

    logic [7:0]  a0, b0, a1, b1;
    logic [14:0] z0, z1, z2;

    assign a0 = a_i[7:0];
    assign b0 = b_i[7:0];
    assign a1 = {1'b0, a_i[14:8]};
    assign b1 = {1'b0, b_i[14:8]};

    assign z0 = clmul8(a0, b0);
    assign z2 = clmul8(a1, b1);
    // Middle term: (a0+a1)(b0+b1) - z0 - z2, subtraction is XOR in GF(2).
    assign z1 = clmul8(a0 ^ a1, b0 ^ b1) ^ z0 ^ z2;

    assign d_o = {14'd0, z0} ^ ({14'd0, z1} << 8) ^ ({14'd0, z2} << 16);

endmodule

// File: rtl/ks15_rr_arb.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst_n  clock / asynchronous active-low reset (pointer -> 0)
//   req_i       per-requester request
//   adv_i       grant is being consumed this cycle; pointer moves past winner
//   gnt_o       one-hot grant (zero when no request)
//   gnt_id_o    index of the granted requester
//   gnt_vld_o   some requester is granted
module ks15_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] idx;

    // Search upward from the pointer with wrap; first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && gnt_vld_o) begin
            ptr_d = IDW'((32'(gnt_id_o) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ks15_mul_arbiter.sv
// Shares one ks15 GF(2) multiplier among NREQ requesters through a
// round-robin arbiter and a 2-stage pipeline (S1 operands, S2 result).
//   clk, rst_n  clock / asynchronous active-low reset
//   bus         ks15_mul_arbiter_if slave: req_valid/req_ready/req_a/req_b,
//               rsp_valid (one-hot owner)/rsp_ready/rsp_data, busy
// Build option: define KS15_ARB_REDUCE_EN to reduce the product modulo
// x^15 + POLY before S2 (rsp_data[28:15] then reads 0). Undefined: raw product.
module ks15_mul_arbiter
    import ks15_arb_pkg::*;
#(
    parameter int unsigned     NREQ = 4,
    parameter int unsigned     IDW  = 2,
    parameter logic [KS_W-1:0] POLY = KS_DEF_POLY
) (
    input logic               clk,
    input logic               rst_n,
    ks15_mul_arbiter_if.slave bus
);

    s1_entry_t s1_q, s1_d;
    s2_entry_t s2_q, s2_d;
    logic      s1_v_q, s1_v_d;
    logic      s2_v_q, s2_v_d;

    logic [IDW-1:0]   s2_id;
    logic             drain, s1_adv, accept, take;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_vld;
    logic [KS_PW-1:0] prod, s2_din;
    logic             unused_s2_id;

    assign s2_id        = s2_q.id[IDW-1:0];
    assign unused_s2_id = ^s2_q.id;

    assign drain  = s2_v_q & bus.rsp_ready[s2_id];
    assign s1_adv = s1_v_q & (~s2_v_q | drain);
    assign accept = ~s1_v_q | s1_adv;
    assign take   = accept & gnt_vld;

    ks15_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req_valid),
        .adv_i     (accept),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    ks15 u_core (
        .a_i (s1_q.a),
        .b_i (s1_q.b),
        .d_o (prod)
    );

`ifdef KS15_ARB_REDUCE_EN
    assign s2_din = {{(KS_PW - KS_W){1'b0}}, gf15_reduce(prod, POLY)};
`else
    logic unused_poly;
    assign unused_poly = ^POLY;
    assign s2_din      = prod;
`endif

    always_comb begin
        s1_d   = s1_q;
        s1_v_d = s1_v_q;
        if (take) begin
            s1_d.id = ID_MAXW'(gnt_id);
            s1_d.a  = bus.req_a[32'(gnt_id) * KS_W +: KS_W];
            s1_d.b  = bus.req_b[32'(gnt_id) * KS_W +: KS_W];
            s1_v_d  = 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    // A refill on s1_adv wins over a drain in the same cycle.
    always_comb begin
        s2_d   = s2_q;
        s2_v_d = s2_v_q;
        if (s1_adv) begin
            s2_d.id = s1_q.id;
            s2_d.d  = s2_din;
            s2_v_d  = 1'b1;
        end else if (drain) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s1_v_q <= 1'b0;
            s2_q   <= '0;
            s2_v_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s1_v_q <= s1_v_d;
            s2_q   <= s2_d;
            s2_v_q <= s2_v_d;
        end
    end

    // Gated by rst_n so no grant is offered while reset is held.
    assign bus.req_ready = rst_n ? (gnt & {NREQ{accept}}) : '0;
    assign bus.rsp_valid = s2_v_q ? (NREQ'(1) << s2_id) : '0;
    assign bus.rsp_data  = s2_q.d;
    assign bus.busy      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_ks15_mul_arbiter.sv
module tb_ks15_mul_arbiter;
    import ks15_arb_pkg::*;

    localparam int unsigned NREQ = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [14:0] cur_a [NREQ];
    logic [14:0] cur_b [NREQ];

    ks15_mul_arbiter_if #(.NREQ(NREQ)) bus ();

    ks15_mul_arbiter #(
        .NREQ (NREQ),
        .IDW  (2),
        .POLY (KS_DEF_POLY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got=timeout exp=finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [28:0] clmul(input logic [14:0] a, input logic [14:0] b);
        logic [28:0] r;
        r = '0;
        for (int i = 0; i < 15; i++) begin
            if (b[i]) r = r ^ ({14'd0, a} << i);
        end
        return r;
    endfunction

    // Horner-style multiply in GF(2^15): shift accumulator by x, fold x^15 into poly.
    function automatic logic [14:0] mulmod(input logic [14:0] a, input logic [14:0] b,
                                           input logic [14:0] poly);
        logic [14:0] r;
        logic        carry;
        r = '0;
        for (int i = 14; i >= 0; i--) begin
            carry = r[14];
            r     = {r[13:0], 1'b0};
            if (carry) r = r ^ poly;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [28:0] ref_mul(input logic [14:0] a, input logic [14:0] b);
`ifdef KS15_ARB_REDUCE_EN
        return {14'd0, mulmod(a, b, KS_DEF_POLY)};
`else
        return clmul(a, b);
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [14:0] a, input logic [14:0] b);
        cur_a[i] = a;
        cur_b[i] = b;
        bus.req_a[i*15 +: 15] = a;
        bus.req_b[i*15 +: 15] = b;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Presents one op, waits (bounded) for accept and response. lat < 0 on timeout.
    task automatic issue_and_wait(input int id, input logic [14:0] a, input logic [14:0] b,
                                  output logic [28:0] data, output logic [NREQ-1:0] vld,
                                  output int lat);
        bit acc;
        bit got;
        acc  = 0;
        got  = 0;
        lat  = -2;
        data = '0;
        vld  = '0;
        tick();
        set_op(id, a, b);
        bus.req_valid[id] = 1'b1;
        for (int n = 0; n < 8 && !acc; n++) begin
            @(negedge clk);
            if (bus.req_ready[id]) acc = 1;
            tick();
        end
        bus.req_valid[id] = 1'b0;
        if (acc) begin
            lat = -1;
            for (int n = 1; n <= 10 && !got; n++) begin
                @(negedge clk);
                if (bus.rsp_valid != '0) begin
                    got  = 1;
                    lat  = n;
                    data = bus.rsp_data;
                    vld  = bus.rsp_valid;
                end else begin
                    tick();
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.rsp_ready = '1;
        for (int i = 0; i < int'(NREQ); i++) set_op(i, 15'($urandom), 15'($urandom));
        bus.req_valid = '1;
        @(negedge clk);
        total += 4;
        if (bus.req_ready !== 4'b0000) begin
            bad++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready);
        end
        if (bus.rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid);
        end
        if (bus.rsp_data !== 29'h0) begin
            bad++; $display("FAIL rst_rsp_data got=%h exp=0", bus.rsp_data);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy);
        end
        tick();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        total += 2;
        if (bus.req_ready !== 4'b0000) begin
            bad++; $display("FAIL idle_no_grant got=%b exp=0000", bus.req_ready);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_single_op();
        logic [28:0]     d;
        logic [NREQ-1:0] v;
        int              l;
        issue_and_wait(0, 15'h0003, 15'h0003, d, v, l);
        total += 3;
        if (l !== 2) begin
            bad++; $display("FAIL single_latency got=%0d exp=2", l);
        end
        if (v !== 4'b0001) begin
            bad++; $display("FAIL single_rsp_valid got=%b exp=0001", v);
        end
        if (d !== 29'h00000005) begin
            bad++; $display("FAIL single_rsp_data got=%h exp=00000005", d);
        end
        tick();
        @(negedge clk);
        total += 3;
        if (bus.rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL single_after_valid got=%b exp=0000", bus.rsp_valid);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL single_after_busy got=%b exp=0", bus.busy);
        end
        if (bus.rsp_data !== 29'h00000005) begin
            bad++; $display("FAIL single_data_hold got=%h exp=00000005", bus.rsp_data);
        end
    endtask

    task automatic test_max_operands();
        logic [28:0]     d;
        logic [NREQ-1:0] v;
        int              l;
        logic [28:0]     exp_d;
`ifdef KS15_ARB_REDUCE_EN
        exp_d = ref_mul(15'h7FFF, 15'h7FFF);
`else
        exp_d = 29'h15555555;
`endif
        issue_and_wait(1, 15'h7FFF, 15'h7FFF, d, v, l);
        total += 3;
        if (l !== 2) begin
            bad++; $display("FAIL max_latency got=%0d exp=2", l);
        end
        if (v !== 4'b0010) begin
            bad++; $display("FAIL max_rsp_valid got=%b exp=0010", v);
        end
        if (d !== exp_d) begin
            bad++; $display("FAIL max_rsp_data got=%h exp=%h", d, exp_d);
        end
    endtask

    task automatic test_reduce_vector();
        logic [28:0]     d;
        logic [NREQ-1:0] v;
        int              l;
        logic [28:0]     exp_d;
`ifdef KS15_ARB_REDUCE_EN
        exp_d = 29'h00000003;
`else
        exp_d = 29'h00008000;
`endif
        issue_and_wait(3, 15'h4000, 15'h0002, d, v, l);
        total += 2;
        if (v !== 4'b1000) begin
            bad++; $display("FAIL reduce_rsp_valid got=%b exp=1000", v);
        end
        if (d !== exp_d) begin
            bad++; $display("FAIL reduce_rsp_data got=%h exp=%h", d, exp_d);
        end
    endtask

    task automatic test_fairness();
        int              exp_id   [8];
        logic [28:0]     exp_prod [8];
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] exp_v;
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) set_op(i, 15'($urandom), 15'($urandom));
        bus.req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                exp_id[c]   = c % 4;
                exp_prod[c] = ref_mul(cur_a[c % 4], cur_b[c % 4]);
                exp_v       = NREQ'(1) << (c % 4);
                total++;
                if (bus.req_ready !== exp_v) begin
                    bad++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp_v);
                end
            end else begin
                total++;
                if (bus.req_ready !== 4'b0000) begin
                    bad++; $display("FAIL fair_idle c=%0d got=%b exp=0000", c, bus.req_ready);
                end
            end
            if (c >= 2) begin
                exp_v = NREQ'(1) << exp_id[c-2];
                total += 2;
                if (bus.rsp_valid !== exp_v) begin
                    bad++; $display("FAIL fair_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_v);
                end
                if (bus.rsp_data !== exp_prod[c-2]) begin
                    bad++; $display("FAIL fair_rsp_data c=%0d got=%h exp=%h", c, bus.rsp_data, exp_prod[c-2]);
                end
            end
            acc = bus.req_ready;
            tick();
            for (int i = 0; i < int'(NREQ); i++) begin
                if (acc[i]) set_op(i, 15'($urandom), 15'($urandom));
            end
            if (c == 7) bus.req_valid = '0;
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] opa [3];
        logic [14:0] opb [3];
        logic [28:0] expd;
        int          k;
        int          got;
        bit          acc;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            opa[j] = 15'($urandom) | 15'h0001;
            opb[j] = 15'($urandom) | 15'h0100;
        end
        k   = 0;
        got = 0;
        bus.rsp_ready    = '1;
        bus.rsp_ready[2] = 1'b0;
        set_op(2, opa[0], opb[0]);
        bus.req_valid = 4'b0100;
        expd = ref_mul(opa[0], opb[0]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 2) begin
                total++;
                if (bus.req_ready !== 4'b0100) begin
                    bad++; $display("FAIL bp_fill_ready c=%0d got=%b exp=0100", c, bus.req_ready);
                end
            end else begin
                total += 4;
                if (bus.req_ready !== 4'b0000) begin
                    bad++; $display("FAIL bp_stall_ready c=%0d got=%b exp=0000", c, bus.req_ready);
                end
                if (bus.rsp_valid !== 4'b0100) begin
                    bad++; $display("FAIL bp_hold_valid c=%0d got=%b exp=0100", c, bus.rsp_valid);
                end
                if (bus.rsp_data !== expd) begin
                    bad++; $display("FAIL bp_hold_data c=%0d got=%h exp=%h", c, bus.rsp_data, expd);
                end
                if (bus.busy !== 1'b1) begin
                    bad++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, bus.busy);
                end
            end
            acc = bus.req_ready[2];
            tick();
            if (acc) begin
                k++;
                if (k < 3) set_op(2, opa[k], opb[k]);
                else bus.req_valid = '0;
            end
        end
        bus.rsp_ready[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                expd = (got < 3) ? ref_mul(opa[got], opb[got]) : 29'h0;
                total += 2;
                if (bus.rsp_valid !== 4'b0100) begin
                    bad++; $display("FAIL bp_drain_valid n=%0d got=%b exp=0100", got, bus.rsp_valid);
                end
                if (bus.rsp_data !== expd) begin
                    bad++; $display("FAIL bp_drain_data n=%0d got=%h exp=%h", got, bus.rsp_data, expd);
                end
                got++;
            end
            acc = bus.req_ready[2];
            tick();
            if (acc) begin
                k++;
                if (k < 3) set_op(2, opa[k], opb[k]);
                else bus.req_valid = '0;
            end
        end
        total += 2;
        if (got !== 3) begin
            bad++; $display("FAIL bp_resp_count got=%0d exp=3", got);
        end
        if (k !== 3) begin
            bad++; $display("FAIL bp_accept_count got=%0d exp=3", k);
        end
    endtask

    task automatic test_reset_midflight();
        logic [28:0]     d;
        logic [NREQ-1:0] v;
        int              l;
        int              cnt;
        bit              acc;
        do_reset();
        cnt              = 0;
        bus.rsp_ready    = '1;
        bus.rsp_ready[0] = 1'b0;
        set_op(0, 15'h1234, 15'h0567);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acc = bus.req_ready[0];
            tick();
            if (acc) begin
                cnt++;
                set_op(0, 15'h0ABC, 15'h0321);
            end
        end
        total += 3;
        if (cnt !== 2) begin
            bad++; $display("FAIL mid_fill_count got=%0d exp=2", cnt);
        end
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy);
        end
        if (bus.rsp_valid !== 4'b0001) begin
            bad++; $display("FAIL mid_valid_before got=%b exp=0001", bus.rsp_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_valid got=%b exp=0000", bus.rsp_valid);
        end
        if (bus.req_ready !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.req_ready);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy);
        end
        if (bus.rsp_data !== 29'h0) begin
            bad++; $display("FAIL mid_rst_data got=%h exp=0", bus.rsp_data);
        end
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        rst_n         = 1'b1;
        issue_and_wait(1, 15'h0F0F, 15'h3003, d, v, l);
        total += 3;
        if (l !== 2) begin
            bad++; $display("FAIL mid_new_latency got=%0d exp=2", l);
        end
        if (v !== 4'b0010) begin
            bad++; $display("FAIL mid_new_valid got=%b exp=0010", v);
        end
        if (d !== ref_mul(15'h0F0F, 15'h3003)) begin
            bad++; $display("FAIL mid_new_data got=%h exp=%h", d, ref_mul(15'h0F0F, 15'h3003));
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 4'b0000) begin
                bad++; $display("FAIL mid_no_stale c=%0d got=%b exp=0000", c, bus.rsp_valid);
            end
        end
    endtask

    typedef struct {
        int          id;
        logic [28:0] prod;
        int          vis;
    } op_t;

    // Model: in-order buffer of at most two ops; an op is visible no earlier than
    // two cycles after its accept cycle and no earlier than the cycle after its
    // predecessor leaves. A new op is taken when there is room or the head leaves.
    task automatic test_random();
        op_t             pend [$];
        op_t             e;
        int              ptr;
        int              g;
        logic [28:0]     last_data;
        logic [NREQ-1:0] acc_mask;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_vld;
        logic [28:0]     exp_data;
        bit              head_vis;
        bit              drain;
        bit              room;
        do_reset();
        ptr       = 0;
        last_data = '0;
        acc_mask  = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (acc_mask[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && ($urandom % 3 == 0)) begin
                    set_op(i, 15'($urandom), 15'($urandom));
                    bus.req_valid[i] = 1'b1;
                end
                bus.rsp_ready[i] = (cyc < 300) ? ($urandom % 4 != 0) : ($urandom % 2 == 0);
            end
            @(negedge clk);
            head_vis = (pend.size() > 0) && (pend[0].vis <= cyc);
            exp_vld  = head_vis ? (NREQ'(1) << pend[0].id) : '0;
            exp_data = head_vis ? pend[0].prod : last_data;
            drain    = head_vis && bus.rsp_ready[pend[0].id];
            room     = (pend.size() < 2) || drain;
            g        = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
                if (g < 0 && bus.req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            end
            exp_rdy = (room && g >= 0) ? (NREQ'(1) << g) : '0;
            total += 4;
            if (bus.req_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
            end
            if (bus.rsp_valid !== exp_vld) begin
                bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_vld);
            end
            if (bus.rsp_data !== exp_data) begin
                bad++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_data);
            end
            if (bus.busy !== (pend.size() > 0)) begin
                bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, pend.size() > 0);
            end
            if (drain) begin
                last_data = pend[0].prod;
                void'(pend.pop_front());
                if (pend.size() > 0 && pend[0].vis < cyc + 1) pend[0].vis = cyc + 1;
            end
            acc_mask = exp_rdy;
            if (exp_rdy != '0) begin
                e.id   = g;
                e.prod = ref_mul(cur_a[g], cur_b[g]);
                e.vis  = cyc + 2;
                pend.push_back(e);
                ptr = (g + 1) % NREQ;
            end
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        test_reset();
        test_single_op();
        test_max_operands();
        test_reduce_vector();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
